// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART TX write port among NumReq
// byte streams, with a mid-packet stall watchdog that reclaims the grant.
module uart_tx_arbiter #(
    parameter int unsigned NumReq      = 4,
    parameter int unsigned DataLength  = 8,
    parameter int unsigned IdleTimeout = 256
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NumReq-1:0]              i_req_valid,
    input  logic [NumReq*DataLength-1:0]   i_req_data,
    input  logic [NumReq-1:0]              i_req_last,
    output logic [NumReq-1:0]              o_req_ready,
    output logic [DataLength-1:0]          o_tx_data,
    output logic                           o_tx_req,
    input  logic                           i_tx_rdy,
    output logic                           o_busy,
    output logic [$clog2(NumReq)-1:0]      o_grant_id,
    output logic                           o_pkt_done,
    output logic                           o_timeout
);

    localparam int unsigned GrantW = $clog2(NumReq);
    localparam int unsigned CntW   = (IdleTimeout > 0) ? $clog2(IdleTimeout + 1) : 1;
    localparam logic [CntW-1:0] StallLast = CntW'((IdleTimeout == 0) ? 0 : IdleTimeout - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              r_state, w_state_next;
    logic [GrantW-1:0]   r_ptr, w_ptr_next;
    logic [GrantW-1:0]   r_grant_id, w_grant_next;
    logic [CntW-1:0]     r_stall_cnt, w_stall_next;
    logic                r_pkt_done, w_pkt_done_next;
    logic                r_timeout, w_timeout_next;

    logic [GrantW-1:0]   w_sel;
    logic [GrantW-1:0]   w_cand;
    logic                w_found;
    logic                w_g_valid;
    logic                w_g_last;
    logic                w_xfer;
    logic [DataLength-1:0] w_g_data;

    assign w_g_valid = i_req_valid[r_grant_id];
    assign w_g_last  = i_req_last[r_grant_id];
    assign w_g_data  = i_req_data[32'(r_grant_id) * DataLength +: DataLength];
    assign w_xfer    = (r_state == ST_BUSY) && w_g_valid && i_tx_rdy;

    // First valid requester strictly after ptr, wrapping; ptr itself is checked last.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int unsigned i = 1; i <= NumReq; i++) begin
            w_cand = GrantW'((32'(r_ptr) + i) % NumReq);
            if (!w_found && i_req_valid[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_ptr_next      = r_ptr;
        w_grant_next    = r_grant_id;
        w_stall_next    = r_stall_cnt;
        w_pkt_done_next = 1'b0;
        w_timeout_next  = 1'b0;
        o_req_ready     = '0;
        o_tx_req        = 1'b0;
        o_tx_data       = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_grant_next = w_sel;
                    w_stall_next = '0;
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                o_req_ready[r_grant_id] = i_tx_rdy;
                if (w_xfer) begin
                    o_tx_req     = 1'b1;
                    o_tx_data    = w_g_data;
                    w_stall_next = '0;
                    if (w_g_last) begin
                        w_pkt_done_next = 1'b1;
                        w_ptr_next      = r_grant_id;
                        w_state_next    = ST_IDLE;
                    end
                end else if (!w_g_valid && (IdleTimeout != 0)) begin
                    // Backpressure (valid high, rdy low) never reaches this branch.
                    if (r_stall_cnt == StallLast) begin
                        w_timeout_next = 1'b1;
                        w_ptr_next     = r_grant_id;
                        w_stall_next   = '0;
                        w_state_next   = ST_IDLE;
                    end else begin
                        w_stall_next = r_stall_cnt + 1'b1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= GrantW'(NumReq - 1);
            r_grant_id  <= '0;
            r_stall_cnt <= '0;
            r_pkt_done  <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ptr       <= w_ptr_next;
            r_grant_id  <= w_grant_next;
            r_stall_cnt <= w_stall_next;
            r_pkt_done  <= w_pkt_done_next;
            r_timeout   <= w_timeout_next;
        end
    end

    assign o_busy     = (r_state == ST_BUSY);
    assign o_grant_id = r_grant_id;
    assign o_pkt_done = r_pkt_done;
    assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes expected FIFO writes,
// a negedge monitor pops and compares every o_tx_req strobe.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic        tx_rdy;

    logic [3:0]  ready, z_ready;
    logic [7:0]  tx_data, z_tx_data;
    logic        tx_req, z_tx_req;
    logic        busy, z_busy;
    logic [1:0]  grant, z_grant;
    logic        pkt_done, z_pkt_done;
    logic        timeout, z_timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NumReq(4), .DataLength(8), .IdleTimeout(8)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
        .i_req_last(req_last), .o_req_ready(ready), .o_tx_data(tx_data),
        .o_tx_req(tx_req), .i_tx_rdy(tx_rdy), .o_busy(busy), .o_grant_id(grant),
        .o_pkt_done(pkt_done), .o_timeout(timeout)
    );

    uart_tx_arbiter #(.NumReq(4), .DataLength(8), .IdleTimeout(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
        .i_req_last(req_last), .o_req_ready(z_ready), .o_tx_data(z_tx_data),
        .o_tx_req(z_tx_req), .i_tx_rdy(tx_rdy), .o_busy(z_busy), .o_grant_id(z_grant),
        .o_pkt_done(z_pkt_done), .o_timeout(z_timeout)
    );

    int checks = 0;
    int errors = 0;

    logic [8:0] rq [4][$];
    logic [3:0] hold = '0;

    typedef struct packed {
        logic [1:0] g;
        logic [7:0] d;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=expired required=event", name);
    endtask

    // Monitor: every FIFO write must match the oldest expected byte and grantee.
    always @(negedge clk) begin
        if (tx_req === 1'b1) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_write");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("tx_data", 32'(tx_data), 32'(e.d));
                chk("write_grant_id", 32'(grant), 32'(e.g));
            end
        end
    end

    // Requester models: present queue head, pop on a ready&valid handshake.
    initial begin
        logic [3:0] acc;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            acc = ready & req_valid;
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++)
                if (acc[k] && rq[k].size() > 0) void'(rq[k].pop_front());
            #1;
            for (int k = 0; k < 4; k++) begin
                if (rq[k].size() > 0 && !hold[k]) begin
                    req_valid[k]       = 1'b1;
                    req_data[k*8 +: 8] = rq[k][0][7:0];
                    req_last[k]        = rq[k][0][8];
                end else begin
                    req_valid[k]       = 1'b0;
                    req_data[k*8 +: 8] = '0;
                    req_last[k]        = 1'b0;
                end
            end
        end
    end

    task automatic load(input int k, input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++)
            rq[k].push_back({(i == n - 1), 8'(first + i)});
    endtask

    task automatic expect_bytes(input int g, input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++)
            sb.push_back({2'(g), 8'(first + i)});
    endtask

    task automatic wait_byte(input logic [7:0] d);
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (tx_req === 1'b1 && tx_data === d) seen = 1;
        end
        if (!seen) fail_now("wait_byte");
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && sb.size() > 0; i++) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) rq[k].delete();
        hold = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int  bad;
        int  n;
        bit  found;
        time t0, t1;
        tx_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_tx_req", 32'(tx_req), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_pulses", 32'({pkt_done, timeout}), 32'd0);

        // Lone requester 2, 3-byte packet
        @(posedge clk); #1;
        load(2, 8'hA1, 3);
        expect_bytes(2, 8'hA1, 3);
        wait_byte(8'hA1);
        @(negedge clk);
        chk("t1_byte2", 32'({tx_req, tx_data}), 32'h1A2);
        @(negedge clk);
        chk("t1_byte3", 32'({tx_req, tx_data}), 32'h1A3);
        @(negedge clk);
        chk("t1_busy_after_last", 32'(busy), 32'd0);
        chk("t1_pkt_done", 32'(pkt_done), 32'd1);
        @(negedge clk);
        chk("t1_pkt_done_once", 32'(pkt_done), 32'd0);
        drain();

        // All four requesters, two 2-byte packets each
        do_reset();
        for (int k = 0; k < 4; k++) begin
            load(k, 8'(k * 16), 2);
            load(k, 8'(k * 16 + 2), 2);
        end
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 4; k++)
                expect_bytes(k, 8'(k * 16 + r * 2), 2);
        wait_byte(8'h00);
        t0 = $time;
        wait_byte(8'h33);
        t1 = $time;
        chk("rr_span_cycles", 32'((t1 - t0) / 10), 32'd22);
        drain();

        // Backpressure for 300 cycles mid-packet never times out
        do_reset();
        load(1, 8'h10, 5);
        expect_bytes(1, 8'h10, 5);
        wait_byte(8'h11);
        @(posedge clk); #1;
        tx_rdy = 1'b0;
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (timeout !== 1'b0 || tx_req !== 1'b0 || busy !== 1'b1 ||
                ready !== 4'b0000 || grant !== 2'd1) bad++;
        end
        chk("bp_hold_cycles_bad", 32'(bad), 32'd0);
        @(posedge clk); #1;
        tx_rdy = 1'b1;
        drain();

        // Stall watchdog (IdleTimeout=8) hands the port to pending requester 3
        do_reset();
        load(1, 8'h40, 5);
        load(3, 8'h70, 2);
        expect_bytes(1, 8'h40, 2);
        expect_bytes(3, 8'h70, 2);
        expect_bytes(1, 8'h42, 3);
        wait_byte(8'h41);
        @(posedge clk); #1;
        hold[1] = 1'b1;
        n = 0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            n++;
            if (timeout === 1'b1) found = 1;
        end
        chk("timeout_cycle", 32'(n), 32'd9);
        chk("timeout_idle", 32'(busy), 32'd0);
        @(negedge clk);
        chk("timeout_one_pulse", 32'(timeout), 32'd0);
        chk("regrant_id", 32'({busy, grant}), 32'h7);
        @(posedge clk); #1;
        hold[1] = 1'b0;
        drain();

        // Reset mid-packet drops the grant
        do_reset();
        load(0, 8'h80, 6);
        expect_bytes(0, 8'h80, 3);
        wait_byte(8'h81);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) rq[k].delete();
        @(negedge clk);
        chk("midrst_outputs", 32'({busy, ready, tx_req, tx_data, pkt_done, timeout}), 32'd0);
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_sb_empty", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
        load(0, 8'h90, 1);
        load(1, 8'hB0, 1);
        expect_bytes(0, 8'h90, 1);
        expect_bytes(1, 8'hB0, 1);
        drain();

        // IdleTimeout=0 instance holds a stalled grant indefinitely
        do_reset();
        load(2, 8'hC0, 2);
        expect_bytes(2, 8'hC0, 2);
        wait_byte(8'hC0);
        @(posedge clk); #1;
        hold[2] = 1'b1;
        bad = 0;
        repeat (10000) begin
            @(negedge clk);
            if (z_timeout !== 1'b0 || z_busy !== 1'b1 || z_grant !== 2'd2) bad++;
        end
        chk("no_watchdog_bad_cycles", 32'(bad), 32'd0);
        @(posedge clk); #1;
        hold[2] = 1'b0;
        drain();

        chk("sb_final", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
